// File: rtl/utim64_irq_ctrl_pkg.sv
// Shared definitions for the utim64 interrupt collector: FSM encodings and
// default parameter values.
package utim64_irq_ctrl_pkg;

    typedef enum logic [1:0] {
        L_PARAM_IDLE = 2'h0,
        L_PARAM_REQ  = 2'h1,
        L_PARAM_GAP  = 2'h2
    } state_t;

    localparam int L_DEF_NUM_W       = 2;
    localparam int L_DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/utim64_irq_sync.sv
// One raw IRQ line: multi-flop synchroniser into iCLOCK, a history flop and
// a single-cycle rising-edge output.
module utim64_irq_sync
    import utim64_irq_ctrl_pkg::*;
#(
    parameter int P_SYNC_STAGES = L_DEF_SYNC_STAGES
) (
    input  logic iCLOCK,
    input  logic inRESET,
    input  logic iRAW,
    output logic oEDGE
);

    logic [P_SYNC_STAGES-1:0] r_sync;
    logic                     r_hist;

    // Shift the raw level through the synchroniser and remember the last output
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[P_SYNC_STAGES-2:0], iRAW};
            r_hist <= r_sync[P_SYNC_STAGES-1];
        end
    end

    assign oEDGE = r_sync[P_SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/utim64_irq_ctrl.sv
// utim64 interrupt collector: synchronises comparator IRQs, latches edges as
// pending bits, masks, arbitrates and hands one interrupt number to the core.
module utim64_irq_ctrl
    import utim64_irq_ctrl_pkg::*;
#(
    parameter int P_NUM_W       = L_DEF_NUM_W,
    parameter int P_SYNC_STAGES = L_DEF_SYNC_STAGES,
    parameter int P_ROUND_ROBIN = 0,
    localparam int L_IRQ_N      = 2**P_NUM_W
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic [L_IRQ_N-1:0] iIRQ_RAW,
    input  logic               iMASK_WRITE,
    input  logic [L_IRQ_N-1:0] iMASK_DATA,
    input  logic               iCLEAR_WRITE,
    input  logic [L_IRQ_N-1:0] iCLEAR_DATA,
    output logic [L_IRQ_N-1:0] oMASK,
    output logic [L_IRQ_N-1:0] oPENDING,
    output logic               oIRQ_VALID,
    output logic [P_NUM_W-1:0] oIRQ_NUM,
    input  logic               iIRQ_ACK
);

    logic [L_IRQ_N-1:0] w_edge;
    logic [L_IRQ_N-1:0] w_pending_nxt;
    logic [L_IRQ_N-1:0] w_req;
    logic               w_ack_hit;

    logic [L_IRQ_N-1:0] r_mask;
    logic [L_IRQ_N-1:0] r_pending;
    state_t             r_state;
    logic               r_valid;
    logic [P_NUM_W-1:0] r_num;
    logic [P_NUM_W-1:0] r_ptr;

    state_t             w_state_nxt;
    logic               w_valid_nxt;
    logic [P_NUM_W-1:0] w_num_nxt;
    logic [P_NUM_W-1:0] w_ptr_nxt;

    // Descending scan so the last hit is the lowest index (fixed) or the
    // nearest index after the pointer (round-robin).
    function automatic logic [P_NUM_W-1:0] f_arbitrate(
        input logic [L_IRQ_N-1:0] req,
        input logic [P_NUM_W-1:0] ptr,
        input logic               rr
    );
        logic [P_NUM_W-1:0] win;
        logic [P_NUM_W-1:0] idx;
        win = '0;
        for (int k = L_IRQ_N; k >= 1; k--) begin
            idx = rr ? (ptr + P_NUM_W'(k)) : P_NUM_W'(k - 1);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    for (genvar g = 0; g < L_IRQ_N; g++) begin : g_sync
        utim64_irq_sync #(
            .P_SYNC_STAGES(P_SYNC_STAGES)
        ) u_sync (
            .iCLOCK (iCLOCK),
            .inRESET(inRESET),
            .iRAW   (iIRQ_RAW[g]),
            .oEDGE  (w_edge[g])
        );
    end

    assign w_ack_hit = (r_state == L_PARAM_REQ) & iIRQ_ACK;
    assign w_req     = r_pending & r_mask;

    // Pending bits: an edge always wins so a coincident ack/clear never loses it
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < L_IRQ_N; i++) begin
            if (w_edge[i]) begin
                w_pending_nxt[i] = 1'b1;
            end else if (w_ack_hit && (r_num == P_NUM_W'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end else if (iCLEAR_WRITE && iCLEAR_DATA[i]) begin
                w_pending_nxt[i] = 1'b0;
            end else begin
                w_pending_nxt[i] = r_pending[i];
            end
        end
    end

    // Mask and pending registers
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_mask    <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (iMASK_WRITE) begin
                r_mask <= iMASK_DATA;
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    // Request FSM next state; the granted number is frozen until acked
    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_num_nxt   = r_num;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            L_PARAM_IDLE: begin
                if (w_req != '0) begin
                    w_num_nxt   = f_arbitrate(w_req, r_ptr, (P_ROUND_ROBIN != 0));
                    w_valid_nxt = 1'b1;
                    w_state_nxt = L_PARAM_REQ;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            L_PARAM_REQ: begin
                if (iIRQ_ACK) begin
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_num;
                    w_state_nxt = L_PARAM_GAP;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end
            L_PARAM_GAP: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = L_PARAM_IDLE;
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = L_PARAM_IDLE;
            end
        endcase
    end

    // FSM state and registered request outputs
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            r_state <= L_PARAM_IDLE;
            r_valid <= 1'b0;
            r_num   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_num   <= w_num_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign oMASK      = r_mask;
    assign oPENDING   = r_pending;
    assign oIRQ_VALID = r_valid;
    assign oIRQ_NUM   = r_num;

endmodule

// File: tb/tb_utim64_irq_ctrl.sv
// Randomised scoreboard bench for utim64_irq_ctrl: fixed-priority and
// round-robin instances share stimulus and are checked against a reference model.
module tb_utim64_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw, mask_d, clr_d;
    logic       mask_we, clr_we, ack_fp, ack_rr;
    logic [3:0] mask_fp, pend_fp, mask_rr, pend_rr;
    logic       val_fp, val_rr;
    logic [1:0] num_fp, num_rr;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    utim64_irq_ctrl #(.P_NUM_W(2), .P_SYNC_STAGES(2), .P_ROUND_ROBIN(0)) dut_fp (
        .iCLOCK(clk), .inRESET(rst_n), .iIRQ_RAW(raw),
        .iMASK_WRITE(mask_we), .iMASK_DATA(mask_d),
        .iCLEAR_WRITE(clr_we), .iCLEAR_DATA(clr_d),
        .oMASK(mask_fp), .oPENDING(pend_fp),
        .oIRQ_VALID(val_fp), .oIRQ_NUM(num_fp), .iIRQ_ACK(ack_fp));

    utim64_irq_ctrl #(.P_NUM_W(2), .P_SYNC_STAGES(2), .P_ROUND_ROBIN(1)) dut_rr (
        .iCLOCK(clk), .inRESET(rst_n), .iIRQ_RAW(raw),
        .iMASK_WRITE(mask_we), .iMASK_DATA(mask_d),
        .iCLEAR_WRITE(clr_we), .iCLEAR_DATA(clr_d),
        .oMASK(mask_rr), .oPENDING(pend_rr),
        .oIRQ_VALID(val_rr), .oIRQ_NUM(num_rr), .iIRQ_ACK(ack_rr));

    // Reference model state: raw samples of the last three edges, mask,
    // and per instance (0 = fixed, 1 = round-robin) pending/request bookkeeping.
    bit [3:0] s1, s2, s3, m_mask;
    bit [3:0] m_pend [2];
    bit       m_val  [2];
    int       m_num  [2];
    int       m_last [2];
    int       m_busy [2];   // 0 free, 1 requesting, 2 settling cycle after an ack
    int       q0[$];
    int       q1[$];

    function automatic int pick(bit [3:0] req, int last, bit rr);
        if (!rr) begin
            for (int i = 0; i < 4; i++) if (req[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (req[(last + k) % 4]) return (last + k) % 4;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model, advanced once per rising edge using the driven inputs
    always @(posedge clk) begin
        bit [3:0] e, np;
        bit       ack, ah;
        if (!rst_n) begin
            s1 = 4'h0; s2 = 4'h0; s3 = 4'h0; m_mask = 4'h0;
            for (int m = 0; m < 2; m++) begin
                m_pend[m] = 4'h0; m_val[m] = 1'b0; m_num[m] = 0;
                m_last[m] = 0; m_busy[m] = 0;
            end
        end else begin
            e  = s2 & ~s3;
            s3 = s2; s2 = s1; s1 = raw;
            for (int m = 0; m < 2; m++) begin
                ack = (m == 0) ? ack_fp : ack_rr;
                ah  = (m_busy[m] == 1) && ack;
                np  = m_pend[m];
                for (int i = 0; i < 4; i++) begin
                    if (e[i]) np[i] = 1'b1;
                    else if (ah && m_num[m] == i) np[i] = 1'b0;
                    else if (clr_we && clr_d[i]) np[i] = 1'b0;
                end
                if (m_busy[m] == 0) begin
                    if ((m_pend[m] & m_mask) != 4'h0) begin
                        m_num[m] = pick(m_pend[m] & m_mask, m_last[m], m == 1);
                        m_val[m] = 1'b1;
                        m_busy[m] = 1;
                        if (m == 0) q0.push_back(m_num[m]);
                        else        q1.push_back(m_num[m]);
                    end
                end else if (m_busy[m] == 1) begin
                    if (ack) begin
                        m_val[m] = 1'b0; m_last[m] = m_num[m]; m_busy[m] = 2;
                    end
                end else begin
                    m_busy[m] = 0;
                end
                m_pend[m] = np;
            end
            if (mask_we) m_mask = mask_d;
        end
    end

    // Monitor: compares visible state and pops expected grants when a request appears
    bit prev_fp = 1'b0, prev_rr = 1'b0;
    int held_fp = 0, held_rr = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mask_fp", int'(mask_fp), int'(m_mask));
            chk("mask_rr", int'(mask_rr), int'(m_mask));
            chk("pending_fp", int'(pend_fp), int'(m_pend[0]));
            chk("pending_rr", int'(pend_rr), int'(m_pend[1]));
            chk("valid_fp", int'(val_fp), int'(m_val[0]));
            chk("valid_rr", int'(val_rr), int'(m_val[1]));
            if (val_fp && !prev_fp) begin
                chk("grant_queue_fp", q0.size() > 0 ? 1 : 0, 1);
                if (q0.size() > 0) begin
                    held_fp = q0.pop_front();
                    chk("num_fp", int'(num_fp), held_fp);
                end
            end else if (val_fp) begin
                chk("num_hold_fp", int'(num_fp), held_fp);
            end
            if (val_rr && !prev_rr) begin
                chk("grant_queue_rr", q1.size() > 0 ? 1 : 0, 1);
                if (q1.size() > 0) begin
                    held_rr = q1.pop_front();
                    chk("num_rr", int'(num_rr), held_rr);
                end
            end else if (val_rr) begin
                chk("num_hold_rr", int'(num_rr), held_rr);
            end
            prev_fp = val_fp;
            prev_rr = val_rr;
        end
    end

    // Stimulus: random IRQ levels held >= 2 cycles, random mask/clear/ack, rare resets
    initial begin
        int hold[4];
        rst_n = 1'b0; raw = 4'h0; mask_d = 4'h0; clr_d = 4'h0;
        mask_we = 1'b0; clr_we = 1'b0; ack_fp = 1'b0; ack_rr = 1'b0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        rst_n = 1'b1;
        mask_we = 1'b1; mask_d = 4'hF;
        @(negedge clk);
        mask_we = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    raw[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(2, 10);
                end else begin
                    hold[i]--;
                end
            end
            rst_n   = ($urandom_range(0, 399) != 0);
            mask_we = ($urandom_range(0, 19) == 0);
            mask_d  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            clr_we  = ($urandom_range(0, 14) == 0);
            clr_d   = 4'($urandom);
            ack_fp  = ($urandom_range(0, 2) == 0);
            ack_rr  = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        rst_n = 1'b1; mask_we = 1'b0; clr_we = 1'b0; ack_fp = 1'b1; ack_rr = 1'b1;
        repeat (10) @(negedge clk);
        chk("drain_fp", q0.size(), 0);
        chk("drain_rr", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
